// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a busy-wait data memory.
// Lane-positions store data, extracts and extends load data, flags misaligned
// or illegal accesses, and stalls the pipeline while memory is busy.
module mem_access_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] STORE_DATA,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WRITEDATA,
  output logic [3:0]  DMEM_BYTEEN,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  input  logic [31:0] DMEM_READDATA,
  input  logic        DMEM_BUSYWAIT,
  output logic [31:0] LOAD_DATA,
  output logic        BUSYWAIT,
  output logic        ACCESS_FAULT
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  byteen_q;
  logic [2:0]  func3_q;
  logic        write_q;

  logic        req, illegal_f3, misalign, fault, valid;
  logic [3:0]  be_new;
  logic [31:0] wd_new, load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        finish;

  // Fault detection and request qualification; only evaluated while idle.
  always_comb begin
    req        = MEM_READ | MEM_WRITE;
    illegal_f3 = (FUNC3 == 3'b011) | (FUNC3 == 3'b110) | (FUNC3 == 3'b111);
    case (FUNC3[1:0])
      2'b01:   misalign = ALU_RESULT[0];
      2'b10:   misalign = |ALU_RESULT[1:0];
      default: misalign = 1'b0;
    endcase
    fault = (state_q == StIdle) & req & (illegal_f3 | misalign | (MEM_WRITE & FUNC3[2]));
    valid = (state_q == StIdle) & req & ~fault;
  end

  // Store lane placement from the incoming request.
  always_comb begin
    be_new = 4'b1111;
    wd_new = STORE_DATA;
    case (FUNC3[1:0])
      2'b00: begin
        be_new = 4'b0001 << ALU_RESULT[1:0];
        wd_new = {4{STORE_DATA[7:0]}};
      end
      2'b01: begin
        be_new = ALU_RESULT[1] ? 4'b1100 : 4'b0011;
        wd_new = {2{STORE_DATA[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension from the registered access.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = DMEM_READDATA[7:0];
      2'b01:   byte_sel = DMEM_READDATA[15:8];
      2'b10:   byte_sel = DMEM_READDATA[23:16];
      default: byte_sel = DMEM_READDATA[31:24];
    endcase
    half_sel = addr_q[1] ? DMEM_READDATA[31:16] : DMEM_READDATA[15:0];
    case (func3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = DMEM_READDATA;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; at least one ACCESS cycle before memory ready is honoured.
  always_comb begin
    finish  = (state_q == StAccess) & ~DMEM_BUSYWAIT;
    state_d = state_q;
    case (state_q)
      StIdle:   if (valid) state_d = StAccess;
      StAccess: if (finish) state_d = StDone;
      default:  state_d = StIdle;
    endcase
  end

  // Access registers captured on acceptance; load result captured on completion.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      byteen_q <= 4'h0;
      func3_q  <= 3'h0;
      write_q  <= 1'b0;
      load_q   <= 32'h0;
    end else begin
      if (valid) begin
        addr_q   <= ALU_RESULT;
        wdata_q  <= wd_new;
        byteen_q <= MEM_WRITE ? be_new : 4'h0;
        func3_q  <= FUNC3;
        write_q  <= MEM_WRITE;
      end
      if (finish && !write_q) load_q <= load_ext;
    end
  end

  // Outputs; strobes derive from state so reset drops them immediately.
  always_comb begin
    DMEM_ADDR      = {addr_q[31:2], 2'b00};
    DMEM_WRITEDATA = wdata_q;
    DMEM_READ      = (state_q == StAccess) & ~write_q;
    DMEM_WRITE     = (state_q == StAccess) & write_q;
    DMEM_BYTEEN    = DMEM_WRITE ? byteen_q : 4'h0;
    BUSYWAIT       = valid | (state_q == StAccess);
    ACCESS_FAULT   = fault;
    LOAD_DATA      = load_q;
  end

endmodule
